// File: rtl/uart_tx_8n1_pkg.sv
// Shared UART definitions: FSM state encodings (common with the receiver),
// the 100 MHz / 9600 baud divisor, the data width and an even-parity helper.
package uart_tx_8n1_pkg;

  localparam int UART_BAUD_100M_9600 = 10417;
  localparam int UART_DATA_BITS      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_t;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts while enabled, one-cycle tick at terminal count,
// held at zero whenever the enable is low. Shared by the transmitter and receiver.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == TC);

endmodule

// File: rtl/uart_tx_8n1.sv
// UART transmitter, LSB first, 1 start / 8 data / STOP_BITS stop bits, with a
// one-byte holding register for gap-free frames. Define UART_PARITY_EN for an even parity bit.
module uart_tx_8n1
  import uart_tx_8n1_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_BAUD_100M_9600,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       start,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam logic LAST_STOP = (STOP_BITS == 2);

  uart_state_t state, state_d;
  logic [UART_DATA_BITS-1:0] shreg, shreg_d;
  logic [UART_DATA_BITS-1:0] hold, hold_d;
  logic [UART_DATA_BITS-1:0] load_byte;
  logic       hold_full, hold_full_d;
  logic [2:0] bit_idx, bit_d;
  logic       stop_cnt, stop_d;
  logic       tx_q, tx_d;
  logic       baud_en, tick;
  logic       frame_end, load_hold, accept, direct, load_en;
`ifdef UART_PARITY_EN
  logic       parity, parity_d;
`endif

  assign baud_en = (state != ST_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .en  (baud_en),
    .tick(tick)
  );

  // An emptying holding register frees its slot on the very same edge,
  // so a start arriving then is taken even though ready reads 0.
  assign frame_end = (state == ST_STOP) && tick && (stop_cnt == LAST_STOP);
  assign load_hold = frame_end && hold_full;
  assign accept    = start && (!hold_full || load_hold);
  assign direct    = accept && ((state == ST_IDLE) || (frame_end && !hold_full));

  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    hold_d      = hold;
    hold_full_d = hold_full;
    bit_d       = bit_idx;
    stop_d      = stop_cnt;
    tx_d        = tx_q;
    load_en     = 1'b0;
    load_byte   = data_in;
`ifdef UART_PARITY_EN
    parity_d    = parity;
`endif

    case (state)
      ST_IDLE: begin
        if (accept) begin
          load_en = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shreg[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          bit_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            stop_d = 1'b0;
`ifdef UART_PARITY_EN
            state_d = ST_PAR;
            tx_d    = parity;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shreg_d = shreg >> 1;
            tx_d    = shreg[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PAR: begin
        if (tick) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt == LAST_STOP) begin
            if (hold_full) begin
              load_en     = 1'b1;
              load_byte   = hold;
              hold_full_d = 1'b0;
            end else if (accept) begin
              load_en = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load_en) begin
      state_d = ST_START;
      shreg_d = load_byte;
      bit_d   = 3'd0;
      tx_d    = 1'b0;
`ifdef UART_PARITY_EN
      parity_d = even_parity(load_byte);
`endif
    end

    // Any accepted byte not going straight to the shifter lands in the holding register.
    if (accept && !direct) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_idx   <= 3'd0;
      stop_cnt  <= 1'b0;
      tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
      bit_idx   <= bit_d;
      stop_cnt  <= stop_d;
      tx_q      <= tx_d;
`ifdef UART_PARITY_EN
      parity    <= parity_d;
`endif
    end
  end

  assign ready = !hold_full;
  assign busy  = baud_en;
  assign done  = frame_end;
  assign tx    = tx_q;

endmodule
